mux_scan_capture: RTL and testbench
===================================

Name: mux_scan_capture

Overview:
- Sequencer wrapped around the 32:1 register-read mux.
- Drives the mux's 5-bit select from a counter, samples the mux output once per cycle, and packs all 32 samples into one wide snapshot word.
- Presents the snapshot downstream on a valid/ready handshake, e.g. to a debug dump or a scan-out port.
- Sits on both sides of the mux: it generates the select and consumes `out`.

Parameters:
- N, 1, width of each mux input/output (matches the mux's N)
- NUM_IN, 32, number of mux inputs scanned; must be a power of two, at least 2
- SEL_W, $clog2(NUM_IN), select width (5 at default)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset; one clock domain only
- start  input  1  request a full scan; sampled on clk
- abort  input  1  synchronous cancel of any scan in progress
- select  output  SEL_W  drives the mux select
- mux_out  input  N  mux `out`, combinational function of select
- word  output  NUM_IN*N  snapshot; slice [i*N +: N] holds input i
- valid  output  1  snapshot complete and stable
- ready  input  1  downstream accepts the snapshot
- busy  output  1  scan in progress

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, idx=0, select=0, word=0, valid=0, busy=0.
- States: IDLE, SCAN, DONE. There is one SEL_W-bit index register idx.
- select = idx in SCAN. select = 0 in IDLE and DONE. select is driven directly from registers, with no combinational path from inputs.
- IDLE:
  - busy=0, valid=0.
  - start=1 at an edge: state moves to SCAN, idx=0.
- SCAN:
  - busy=1, valid=0.
  - Every edge: word[idx*N +: N] <= mux_out.
  - If idx==NUM_IN-1: state moves to DONE and idx returns to 0. Otherwise idx increments by 1.
  - The mux is combinational, so the value captured at an edge is from the input selected during the preceding cycle.
  - start is ignored while in SCAN.
- DONE:
  - valid=1, busy=0, word held stable.
  - ready=1 and start=0: state moves to IDLE; valid is 0 from the next cycle.
  - ready=1 and start=1: back-to-back; state moves to SCAN, idx=0.
  - ready=0: remain in DONE; start is ignored.
- Latency: start sampled at edge E0 → captures at E1..E(NUM_IN) → valid=1 from edge E(NUM_IN), i.e. 32 cycles at default.
- Throughput: one snapshot per NUM_IN+1 cycles with ready held high and start held high.
- abort=1 at an edge in any state:
  - Next state is IDLE, idx=0, valid=0, busy=0.
  - word is not cleared; partial contents may remain and are undefined to the consumer.
  - abort has priority over start, ready and the scan-complete transition.
- Mid-operation reset forces the reset values immediately, without waiting for clk.
- idx wrap: idx never exceeds NUM_IN-1; there is no modulo overflow path.
- word bits are written only in SCAN. The slice being written is selected by idx only.

Decomposition:
- Shared package mux_scan_pkg:
  - typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} scan_state_t
  - localparam DEFAULT_NUM_IN = 32
- One natural sub-module: scan_counter.
  - Parameterised SEL_W up-counter with clear/enable.
  - Has a terminal-count flag (idx==NUM_IN-1).
  - Uses the same async active-low rst.
- All remaining logic (FSM and capture register) is in the top module.

Test Plan:
- Reset: hold rst=0, toggle clk → select=0, word=0, valid=0, busy=0. Drop rst mid-SCAN (idx=7) → all outputs return to reset values with no clock edge.
- Single scan: mux inputs inK = K[0] (N=1), start pulse at E0 → select sequences 0..31 over 32 cycles. valid rises at E32. word=32'hAAAAAAAA. busy high for exactly 32 cycles.
- Backpressure: ready=0 for 10 cycles after valid → word is stable and valid stays 1. start pulses during the stall are ignored. ready=1 → valid=0 next cycle.
- Back-to-back: start=1 and ready=1 held continuously, inputs changed between scans → valid pulses 1 cycle in every 33. Each word matches the inputs present during its scan.
- Abort: start, then abort at idx=12 → IDLE next cycle, valid never asserts. A new start then yields a correct full word after 32 cycles.
- N=8 variant: inK = 8'(K*3) → word slice i equals i*3 for all i. The last slice (i=31) equals 93.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the register-read mux scan sequencer.
//   scan_state_t   : sequencer FSM states
//   DEFAULT_NUM_IN : default number of mux inputs scanned
package mux_scan_pkg;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} scan_state_t;

    localparam int DEFAULT_NUM_IN = 32;

endpackage

// File: rtl/scan_counter.sv
// Index counter for the scan sequencer. Counts 0..NUM_IN-1 and wraps to 0
// on the terminal count, so it can never leave the valid select range.
//   clk, rst : clock, async active-low reset
//   clr      : synchronous clear to 0 (priority over en)
//   en       : advance one step
//   idx      : current index
//   tc       : idx == NUM_IN-1
module scan_counter #(
    parameter int NUM_IN = 32,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [SEL_W-1:0] idx,
    output logic             tc
);

    assign tc = (idx == SEL_W'(NUM_IN - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (en) begin
            idx <= tc ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/mux_scan_capture.sv
// Sequencer around a NUM_IN:1 register-read mux. Steps the mux select from
// 0 to NUM_IN-1, captures the mux output each cycle into a packed snapshot
// and offers the snapshot downstream with a valid/ready handshake.
//   clk, rst : clock, async active-low reset
//   start    : request a full scan
//   abort    : synchronous cancel, highest priority
//   select   : mux select (register-driven, 0 outside SCAN)
//   mux_out  : mux output, combinational in select
//   word     : snapshot, slice [i*N +: N] holds input i
//   valid    : snapshot complete and stable
//   ready    : downstream accepts snapshot
//   busy     : scan in progress
module mux_scan_capture
    import mux_scan_pkg::*;
#(
    parameter int N      = 1,
    parameter int NUM_IN = DEFAULT_NUM_IN,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic [SEL_W-1:0]    select,
    input  logic [N-1:0]        mux_out,
    output logic [NUM_IN*N-1:0] word,
    output logic                valid,
    input  logic                ready,
    output logic                busy
);

    scan_state_t      state, state_nxt;
    logic [SEL_W-1:0] idx;
    logic             tc;
    logic             cnt_clr, cnt_en;

    scan_counter #(.NUM_IN(NUM_IN), .SEL_W(SEL_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .idx (idx),
        .tc  (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SCAN;
                    cnt_clr   = 1'b1;
                end
            end
            S_SCAN: begin
                // counter wraps to 0 on its own at terminal count
                cnt_en = 1'b1;
                if (tc) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (ready) begin
                    state_nxt = start ? S_SCAN : S_IDLE;
                    cnt_clr   = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_clr   = 1'b1;
            end
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
            cnt_en    = 1'b0;
            cnt_clr   = 1'b1;
        end
    end

    // The value captured at an edge is the mux output for the select held
    // during the preceding cycle, which is exactly idx.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word <= '0;
        end else if (state == S_SCAN && !abort) begin
            word[idx*N +: N] <= mux_out;
        end
    end

    assign select = (state == S_SCAN) ? idx : '0;
    assign valid  = (state == S_DONE);
    assign busy   = (state == S_SCAN);

endmodule

// File: tb/tb_mux_scan_capture.sv
module tb_mux_scan_capture;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // N=1 instance
    logic        start1 = 0, abort1 = 0, ready1 = 0;
    logic [4:0]  sel1;
    logic        mux1;
    logic [31:0] word1;
    logic        valid1, busy1;
    logic [31:0] in1 = '0;
    assign mux1 = in1[sel1];

    // N=8 instance
    logic         start8 = 0, abort8 = 0, ready8 = 0;
    logic [4:0]   sel8;
    logic [7:0]   mux8;
    logic [255:0] word8;
    logic         valid8, busy8;
    logic [7:0]   in8 [32];
    assign mux8 = in8[sel8];

    mux_scan_capture #(.N(1), .NUM_IN(32)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .select(sel1),
        .mux_out(mux1), .word(word1), .valid(valid1), .ready(ready1), .busy(busy1)
    );

    mux_scan_capture #(.N(8), .NUM_IN(32)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort8), .select(sel8),
        .mux_out(mux8), .word(word8), .valid(valid8), .ready(ready8), .busy(busy8)
    );

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] inp;
        int          stall;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: snapshot slice i is whatever input i held during the scan.
    function automatic logic [31:0] model1(input logic [31:0] inputs);
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++) w[i] = inputs[i];
        return w;
    endfunction

    function automatic logic [255:0] model8();
        logic [255:0] w = '0;
        for (int i = 0; i < 32; i++) w[i*8 +: 8] = in8[i];
        return w;
    endfunction

    task automatic scan1(input logic [31:0] exp, input int stall, input string tag);
        logic ok;
        logic [31:0] held;
        start1 = 1; tick(); start1 = 0;
        ok = 1;
        for (int k = 0; k < 32; k++) begin
            if (sel1 != 5'(k) || !busy1 || valid1) ok = 0;
            tick();
        end
        chk({tag, " seq"}, 256'(ok), 256'(1));
        chk({tag, " valid/busy"}, 256'({valid1, busy1}), 256'(2'b10));
        chk({tag, " word"}, 256'(word1), 256'(exp));
        held = word1;
        ok = 1;
        for (int s = 0; s < stall; s++) begin
            start1 = s[0];
            tick();
            if (!valid1 || busy1 || word1 != held) ok = 0;
        end
        start1 = 0;
        if (stall > 0) chk({tag, " stall hold"}, 256'(ok), 256'(1));
        ready1 = 1; tick(); ready1 = 0;
        chk({tag, " release"}, 256'({valid1, busy1}), 256'(0));
    endtask

    task automatic scan8(input string tag);
        logic ok;
        start8 = 1; tick(); start8 = 0;
        ok = 1;
        for (int k = 0; k < 32; k++) begin
            if (sel8 != 5'(k) || !busy8 || valid8) ok = 0;
            tick();
        end
        chk({tag, " seq"}, 256'(ok), 256'(1));
        chk({tag, " valid"}, 256'(valid8), 256'(1));
        chk({tag, " word"}, word8, model8());
        ready8 = 1; tick(); ready8 = 0;
        chk({tag, " release"}, 256'(valid8), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ok;
        logic [31:0] b2b [3];

        for (int i = 0; i < 32; i++) in8[i] = '0;
        tbl[0] = '{32'hAAAA_AAAA, 10, 32'hAAAA_AAAA};   // in[K] = K[0]
        tbl[1] = '{32'h0000_0000,  0, 32'h0000_0000};
        tbl[2] = '{32'hFFFF_FFFF,  2, 32'hFFFF_FFFF};
        tbl[3] = '{32'h8000_0001,  1, 32'h8000_0001};

        // reset held with clock running
        repeat (3) @(posedge clk);
        #1;
        chk("reset sel", 256'(sel1), 256'(0));
        chk("reset word", 256'(word1), 256'(0));
        chk("reset valid/busy", 256'({valid1, busy1}), 256'(0));
        chk("reset word8", word8, 256'(0));
        rst = 1;
        tick();

        // table-driven scans
        for (int i = 0; i < 4; i++) begin
            in1 = tbl[i].inp;
            scan1(tbl[i].exp, tbl[i].stall, $sformatf("vec%0d", i));
        end

        // random inputs
        for (int r = 0; r < 6; r++) begin
            in1 = $urandom;
            scan1(model1(in1), int'($urandom_range(0, 5)), $sformatf("rnd%0d", r));
        end

        // back-to-back with start and ready held high
        for (int s = 0; s < 3; s++) b2b[s] = $urandom;
        in1 = b2b[0];
        start1 = 1; ready1 = 1;
        tick();
        for (int s = 0; s < 3; s++) begin
            ok = 1;
            for (int k = 0; k < 32; k++) begin
                if (valid1 || !busy1) ok = 0;
                tick();
            end
            chk($sformatf("b2b%0d gap", s), 256'(ok), 256'(1));
            chk($sformatf("b2b%0d valid", s), 256'(valid1), 256'(1));
            chk($sformatf("b2b%0d word", s), 256'(word1), 256'(model1(b2b[s])));
            if (s < 2) in1 = b2b[s+1];
            else       start1 = 0;
            tick();
            chk($sformatf("b2b%0d pulse", s), 256'(valid1), 256'(0));
        end
        ready1 = 0;

        // abort at idx 12
        in1 = $urandom;
        start1 = 1; tick(); start1 = 0;
        repeat (12) tick();
        chk("abort pre sel", 256'(sel1), 256'(12));
        abort1 = 1; tick(); abort1 = 0;
        chk("abort idle", 256'({sel1, valid1, busy1}), 256'(0));
        ok = 1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (valid1 || busy1) ok = 0;
        end
        chk("abort no valid", 256'(ok), 256'(1));
        in1 = $urandom;
        scan1(model1(in1), 0, "post-abort");

        // N=8: in[K] = K*3
        for (int i = 0; i < 32; i++) in8[i] = 8'(i * 3);
        scan8("n8 pattern");
        chk("n8 last slice", 256'(word8[31*8 +: 8]), 256'(93));
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++) in8[i] = 8'($urandom);
            scan8($sformatf("n8 rnd%0d", r));
        end

        // asynchronous reset mid-scan
        in1 = 32'hFFFF_FFFF;
        start1 = 1; tick(); start1 = 0;
        repeat (7) tick();
        chk("midreset pre sel", 256'(sel1), 256'(7));
        #2 rst = 0;
        #1;
        chk("midreset outputs", 256'({sel1, word1, valid1, busy1}), 256'(0));
        tick();
        rst = 1;
        tick();
        chk("midreset stays idle", 256'({valid1, busy1}), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
